// File: rtl/demux4_dispatch_if.sv
// Handshake and bus bundle for the 1:4 dispatch controller.
// master: the upstream producer / consumer side; slave: the controller.
interface demux4_dispatch_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          mode;
  logic [1:0]    dest;
  logic [3:0]    out_ready;
  logic [3:0]    out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    sel;
  logic          busy;
  logic [7:0]    retarget_cnt;

  modport master (
    output in_valid, in_data, mode, dest, out_ready,
    input  in_ready, out_valid, out_data, sel, busy, retarget_cnt
  );

  modport slave (
    input  in_valid, in_data, mode, dest, out_ready,
    output in_ready, out_valid, out_data, sel, busy, retarget_cnt
  );
endinterface

// File: rtl/demux4_dispatch_ctrl.sv
// Sequencing controller for a 1:4 demux datapath.
// A one-entry buffer takes items over valid/ready and delivers each to one of
// four consumers, round-robin (mode=0) or to an explicit port (mode=1).
// Round-robin items skip a consumer that stalls for TIMEOUT cycles.
// Optional build macro: DEMUX_CTRL_STATS_EN adds a saturating 8-bit counter of
// timeout retargets on retarget_cnt; without it retarget_cnt is tied to zero.
module demux4_dispatch_ctrl #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  demux4_dispatch_if.slave   bus
);

  typedef enum logic {IDLE, SEND} state_t;

  // Stall counter compare points; the retarget fires on the TIMEOUT-th stall.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] TO_MAX  = 8'(TIMEOUT);

  state_t        state_q;
  logic [DW-1:0] data_q;
  logic [1:0]    sel_q;
  logic [1:0]    rr_q;
  logic          mode_q;
  logic [3:0]    out_valid_q;
  logic [7:0]    stall_q;
  logic          in_ready_q;
  logic          busy_q;

  logic          ready_sel;
  logic          timeout_hit;
  logic [1:0]    cap_sel;
  logic [1:0]    next_sel;

  function automatic logic [3:0] onehot(input logic [1:0] s);
    return 4'b0001 << s;
  endfunction

  // Only the currently targeted consumer's ready matters.
  assign ready_sel   = bus.out_ready[sel_q];
  assign timeout_hit = (stall_q == TO_LAST);
  assign cap_sel     = bus.mode ? bus.dest : rr_q;
  assign next_sel    = sel_q + 2'd1;

  // Dispatch FSM: capture into the buffer, present, transfer or retarget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      sel_q       <= 2'd0;
      rr_q        <= 2'd0;
      mode_q      <= 1'b0;
      out_valid_q <= 4'b0000;
      stall_q     <= 8'd0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            data_q      <= bus.in_data;
            mode_q      <= bus.mode;
            sel_q       <= cap_sel;
            out_valid_q <= onehot(cap_sel);
            stall_q     <= 8'd0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= SEND;
          end
        end
        SEND: begin
          if (ready_sel) begin
            // A transfer beats a timeout landing on the same edge.
            out_valid_q <= 4'b0000;
            stall_q     <= 8'd0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
            if (!mode_q) begin
              rr_q <= next_sel;
            end
          end else if (!mode_q && timeout_hit) begin
            // Round-robin item skips the blocked consumer; item is kept.
            sel_q       <= next_sel;
            out_valid_q <= onehot(next_sel);
            stall_q     <= 8'd0;
          end else if (stall_q != TO_MAX) begin
            stall_q <= stall_q + 8'd1;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = data_q;
  assign bus.sel       = sel_q;

`ifdef DEMUX_CTRL_STATS_EN
  logic [7:0] retarget_cnt_q;

  // Saturating count of timeout retargets, same condition the FSM acts on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retarget_cnt_q <= 8'd0;
    end else if ((state_q == SEND) && !ready_sel && !mode_q && timeout_hit &&
                 (retarget_cnt_q != 8'hFF)) begin
      retarget_cnt_q <= retarget_cnt_q + 8'd1;
    end
  end

  assign bus.retarget_cnt = retarget_cnt_q;
`else
  assign bus.retarget_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_demux4_dispatch_ctrl.sv
// Scoreboard bench for demux4_dispatch_ctrl: the driver predicts each item's
// destination port, presentation length and retarget total and queues it; a
// monitor pops and compares on every transfer.
module tb_demux4_dispatch_ctrl;
  localparam int DW      = 8;
  localparam int TIMEOUT = 15;

  typedef struct {
    logic [7:0] data;
    logic [1:0] port;
    int         dur;
    logic [7:0] rcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  demux4_dispatch_if #(.DW(DW)) bus();

  demux4_dispatch_ctrl #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   nvec = 0;
  int   nfail = 0;
  int   delivered = 0;
  int   cur_dur = 0;
  int   rr_model = 0;
  int   rtotal = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    nvec++;
    nfail++;
    $display("FAIL %s: bound expired", nm);
  endtask

  function automatic logic [7:0] exp_rcnt(input int total);
`ifdef DEMUX_CTRL_STATS_EN
    return (total > 255) ? 8'hFF : 8'(total);
`else
    return 8'd0;
`endif
  endfunction

  // Monitor: a transfer happens on the next edge when the targeted ready is high.
  always @(negedge clk) begin
    if (rst_n && (bus.out_valid != 4'b0000)) begin
      cur_dur++;
      chk("onehot", {28'd0, bus.out_valid}, {28'd0, 4'b0001 << bus.sel});
      if (bus.out_ready[bus.sel]) begin
        if (q.size() == 0) begin
          fail_now("unexpected_delivery");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("port", {30'd0, bus.sel}, {30'd0, e.port});
          chk("data", {24'd0, bus.out_data}, {24'd0, e.data});
          chk("duration", cur_dur, e.dur);
          chk("retarget_cnt", {24'd0, bus.retarget_cnt}, {24'd0, e.rcnt});
          chk("busy", {31'd0, bus.busy}, 32'd1);
        end
        delivered++;
        cur_dur = 0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  {31'd0, bus.in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {28'd0, bus.out_valid}, 32'd0);
    chk({tag, "_out_data"},  {24'd0, bus.out_data}, 32'd0);
    chk({tag, "_sel"},       {30'd0, bus.sel}, 32'd0);
    chk({tag, "_busy"},      {31'd0, bus.busy}, 32'd0);
    chk({tag, "_rcnt"},      {24'd0, bus.retarget_cnt}, 32'd0);
  endtask

  // Send one item. Cycle t of presentation sees out_ready = hold_mask for
  // t < hold, then mask. Round-robin targets advance every TIMEOUT cycles.
  task automatic send_item(input logic [7:0] data, input logic mode, input logic [1:0] dest,
                           input logic [3:0] mask, input int hold, input logic [3:0] hold_mask);
    exp_t e;
    int   found;
    int   d0;
    int   t;
    found = 0;
    for (int tt = 0; tt < 1000 && found == 0; tt++) begin
      int p;
      logic [3:0] r;
      p = mode ? int'(dest) : (rr_model + tt / TIMEOUT) % 4;
      r = (tt >= hold) ? mask : hold_mask;
      if (r[p]) begin
        found  = 1;
        e.port = 2'(p);
        e.dur  = tt + 1;
        if (!mode) begin
          rtotal  += tt / TIMEOUT;
          rr_model = (p + 1) % 4;
        end
      end
    end
    e.data = data;
    e.rcnt = exp_rcnt(rtotal);
    q.push_back(e);

    t = 0;
    while (!bus.in_ready && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!bus.in_ready) fail_now("in_ready_wait");
    d0 = delivered;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.mode     = mode;
    bus.dest     = dest;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    t = 0;
    while (delivered == d0 && t < 2000) begin
      bus.out_ready = (t >= hold) ? mask : hold_mask;
      bus.mode      = 1'($urandom);
      bus.dest      = 2'($urandom);
      @(posedge clk);
      #1;
      t++;
    end
    if (delivered == d0) fail_now("delivery_wait");
    bus.out_ready = 4'b0000;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.mode      = 1'b0;
    bus.dest      = 2'd0;
    bus.out_ready = 4'b0000;

    // Power-on reset held for 3 cycles.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_release_sel", {30'd0, bus.sel}, 32'd0);
    chk("post_release_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Round-robin with all consumers ready: ports 0,1,2,3,0.
    for (int i = 0; i < 5; i++) send_item(8'hA1 + 8'(i), 1'b0, 2'd0, 4'b1111, 0, 4'b0000);

    // Fixed destination 2 blocked for 40 cycles, no retarget.
    send_item(8'h5C, 1'b1, 2'd2, 4'b0100, 40, 4'b0000);

    // Round-robin from pointer 1 with consumer 1 blocked: moves to port 2.
    send_item(8'h3E, 1'b0, 2'd0, 4'b1101, 0, 4'b0000);

    // Ready rises exactly on the timeout cycle: transfer wins on original port.
    send_item(8'h77, 1'b0, 2'd0, 4'b1111, TIMEOUT - 1, 4'b0000);

    // Randomized mix of both modes, stalls and retargets.
    for (int i = 0; i < 40; i++) begin
      logic       m;
      logic [1:0] d;
      logic [3:0] mk;
      logic [3:0] hm;
      int         h;
      m  = 1'($urandom);
      d  = 2'($urandom);
      hm = 4'($urandom);
      mk = 4'($urandom_range(1, 15));
      if (m) begin
        hm[d] = 1'b0;
        mk[d] = 1'b1;
        h     = $urandom_range(0, 40);
      end else begin
        h     = $urandom_range(0, 35);
      end
      send_item(8'($urandom), m, d, mk, h, hm);
    end

    // Reset pulse mid-SEND discards the buffered item.
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hFF;
    bus.mode      = 1'b0;
    bus.out_ready = 4'b0000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_send_busy", {31'd0, bus.busy}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    cur_dur  = 0;
    rr_model = 0;
    rtotal   = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_item(8'h11, 1'b0, 2'd0, 4'b1111, 0, 4'b0000);
    send_item(8'h22, 1'b0, 2'd0, 4'b1011, 0, 4'b0000);

    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
